// File: rtl/pong_match_sequencer.sv
// Match-level sequencer for pong: serve arbitration, point counting,
// winner detection and match restart. Drives game_state for the paddle
// and ball logic and issues the serve launch pulse to the ball engine.
module pong_match_sequencer #(
    parameter logic [3:0] WIN_SCORE     = 4'd7,
    parameter logic [7:0] HOLDOFF_TICKS = 8'd30,
    parameter logic [9:0] SERVE_TIMEOUT = 10'd300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       p1_serve_btn,
    input  logic       p2_serve_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       restart,
    output logic [1:0] game_state,
    output logic       serve_launch,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned SCORE_W = 4;

    localparam logic [CNT_W-1:0]   HOLDOFF_CNT = CNT_W'(HOLDOFF_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = 4'd15;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam logic SERVER_P1 = 1'b0;
    localparam logic SERVER_P2 = 1'b1;

    typedef enum logic [1:0] {
        ST_P1_SERVE = 2'd0,
        ST_P2_SERVE = 2'd1,
        ST_PLAYING  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   serve_cnt;
    logic               p1_prev;
    logic               p2_prev;
    logic               last_server;

    logic               p1_press;
    logic               p2_press;
    logic               holdoff_met;
    logic               timeout_hit;
    logic [SCORE_W-1:0] p1_inc;
    logic [SCORE_W-1:0] p2_inc;

    assign game_state = state;

    // Rising-edge press detection, hold-off / auto-serve conditions and saturating score increments.
    always_comb begin
        p1_press    = p1_serve_btn & ~p1_prev;
        p2_press    = p2_serve_btn & ~p2_prev;
        holdoff_met = (serve_cnt >= HOLDOFF_CNT);
        timeout_hit = frame_tick && (CNT_W'(serve_cnt + CNT_W'(1)) == SERVE_TIMEOUT);
        p1_inc      = (p1_score == SCORE_MAX) ? SCORE_MAX : SCORE_W'(p1_score + SCORE_W'(1));
        p2_inc      = (p2_score == SCORE_MAX) ? SCORE_MAX : SCORE_W'(p2_score + SCORE_W'(1));
    end

    // Match FSM with registered outputs; restart takes priority over any in-flight event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_P1_SERVE;
            serve_cnt    <= '0;
            p1_prev      <= 1'b0;
            p2_prev      <= 1'b0;
            last_server  <= SERVER_P1;
            serve_launch <= 1'b0;
            serve_dir    <= 1'b0;
            p1_score     <= '0;
            p2_score     <= '0;
            winner       <= WIN_NONE;
        end else begin
            p1_prev      <= p1_serve_btn;
            p2_prev      <= p2_serve_btn;
            serve_launch <= 1'b0;

            if (restart) begin
                p1_score  <= '0;
                p2_score  <= '0;
                winner    <= WIN_NONE;
                serve_cnt <= '0;
                if (state == ST_DONE && winner == WIN_P1) begin
                    state <= ST_P2_SERVE;
                end else begin
                    state <= ST_P1_SERVE;
                end
            end else begin
                case (state)
                    ST_P1_SERVE: begin
                        if ((p1_press && holdoff_met) || timeout_hit) begin
                            state        <= ST_PLAYING;
                            serve_launch <= 1'b1;
                            serve_dir    <= 1'b0;
                            last_server  <= SERVER_P1;
                        end else if (frame_tick && serve_cnt != SERVE_TIMEOUT) begin
                            serve_cnt <= CNT_W'(serve_cnt + CNT_W'(1));
                        end
                    end

                    ST_P2_SERVE: begin
                        if ((p2_press && holdoff_met) || timeout_hit) begin
                            state        <= ST_PLAYING;
                            serve_launch <= 1'b1;
                            serve_dir    <= 1'b1;
                            last_server  <= SERVER_P2;
                        end else if (frame_tick && serve_cnt != SERVE_TIMEOUT) begin
                            serve_cnt <= CNT_W'(serve_cnt + CNT_W'(1));
                        end
                    end

                    ST_PLAYING: begin
                        if (miss_left && miss_right) begin
                            // Double miss is a let: replay the serve of whoever served last.
                            serve_cnt <= '0;
                            state     <= (last_server == SERVER_P2) ? ST_P2_SERVE : ST_P1_SERVE;
                        end else if (miss_left) begin
                            p2_score  <= p2_inc;
                            serve_cnt <= '0;
                            if (p2_inc == WIN_SCORE) begin
                                state  <= ST_DONE;
                                winner <= WIN_P2;
                            end else begin
                                state <= ST_P1_SERVE;
                            end
                        end else if (miss_right) begin
                            p1_score  <= p1_inc;
                            serve_cnt <= '0;
                            if (p1_inc == WIN_SCORE) begin
                                state  <= ST_DONE;
                                winner <= WIN_P1;
                            end else begin
                                state <= ST_P2_SERVE;
                            end
                        end
                    end

                    ST_DONE: begin
                        state <= ST_DONE;
                    end

                    default: begin
                        state <= ST_P1_SERVE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pong_match_sequencer.md
Name: pong_match_sequencer

Overview:
- Match-level FSM that drives the 2-bit game_state consumed by the paddle controller and ball logic.
- Decides who serves, detects serve presses, counts points from ball-miss events, declares the winner and handles match restart.
- Sits between the player button synchronisers, the ball engine (miss pulses in, launch pulse out) and the score display.

Parameters:
- WIN_SCORE, 4'd7, points needed to win (legal 1..15).
- HOLDOFF_TICKS, 8'd30, frame ticks after entering a serve state during which serve presses are ignored.
- SERVE_TIMEOUT, 10'd300, frame ticks in a serve state (counted from entry) after which the serve launches automatically.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  single-cycle strobe, once per video frame.
- p1_serve_btn  in  1  P1 serve button, synchronised, level, active-high.
- p2_serve_btn  in  1  P2 serve button, synchronised, level, active-high.
- miss_left  in  1  single-cycle pulse: ball passed P1 paddle.
- miss_right  in  1  single-cycle pulse: ball passed P2 paddle.
- restart  in  1  single-cycle pulse: start a new match.
- game_state  out  2  0=P1_SERVE, 1=P2_SERVE, 2=PLAYING, 3=DONE.
- serve_launch  out  1  single-cycle pulse, ball released.
- serve_dir  out  1  0=toward P2 (right), 1=toward P1 (left); valid with serve_launch and held until the next launch.
- p1_score  out  4  P1 points.
- p2_score  out  4  P2 points.
- winner  out  2  0=none, 1=P1, 2=P2.

Behaviour:
- All outputs registered. Reset values: game_state=P1_SERVE, serve_launch=0, serve_dir=0, scores=0, winner=0. Internal state also resets: hold-off counter=0, timeout counter=0, button-history registers=0, last_server=P1.
- Button edges: each button is registered; a press is prev=0 & cur=1. A held button never re-triggers.
- Serve-state counter: cleared on the cycle the FSM enters a serve state; increments on each frame_tick while in that state; saturates at SERVE_TIMEOUT.
- P1_SERVE exits to PLAYING when either condition holds:
  - a P1 press occurs with counter >= HOLDOFF_TICKS; or
  - the counter reaches SERVE_TIMEOUT (the auto-serve fires on the frame_tick that makes counter == SERVE_TIMEOUT).
  - On exit: serve_launch=1 for exactly the cycle on which game_state first reads PLAYING; serve_dir=0; last_server=P1.
  - P2 button presses are ignored in this state.
- P2_SERVE: mirror of P1_SERVE using the P2 button; sets serve_dir=1 and last_server=P2.
- PLAYING:
  - miss_left alone: p2_score+1. If the new value == WIN_SCORE, go to DONE with winner=2; otherwise go to P1_SERVE (the conceding player serves).
  - miss_right alone: p1_score+1. If the new value == WIN_SCORE, go to DONE with winner=1; otherwise go to P2_SERVE.
  - miss_left and miss_right in the same cycle: no score change; go to the serve state of last_server.
  - Next state and score update land on the same clock edge, one cycle after the miss pulse.
- Miss pulses outside PLAYING are ignored.
- DONE: scores and winner frozen; buttons and misses ignored.
- restart in DONE:
  - scores=0 and winner=0 next cycle;
  - go to the loser's serve state (winner=1 → P2_SERVE, winner=2 → P1_SERVE);
  - serve counter cleared.
- restart in any other state: scores=0, winner=0, go to P1_SERVE, counter cleared. This aborts a point in flight.
- Scores saturate at 15. With a legal WIN_SCORE the saturation path is unreachable, but it must still be implemented.
- Async reset mid-operation: all state returns to reset values immediately; no serve_launch pulse is generated on reset release.
- Encoding 3 is always DONE; no illegal states exist.

Test Plan:
- Reset, then 30 frame_ticks, then P1 press → game_state 0→2, one-cycle serve_launch, serve_dir=0. Repeat with the press after only 10 ticks → ignored, state stays 0.
- In PLAYING, pulse miss_left → next cycle p2_score=1, game_state=0. Pulse miss_right from PLAYING → p1_score=1, game_state=1.
- Hold P2 button through 300 frame_ticks in P2_SERVE without a new edge → auto-launch at tick 300, serve_dir=1, exactly one pulse.
- Score p1 to 6, then miss_right → p1_score=7, winner=1, game_state=3. Further misses and presses leave everything unchanged. restart → scores 0, winner 0, game_state=1.
- Simultaneous miss_left and miss_right after P2 served → scores unchanged, game_state=1. miss_left while in P1_SERVE → no change.
- Assert reset while PLAYING with score 3-2 → immediately game_state=0, scores 0, serve_launch=0 through reset release.
